// File: rtl/csi_lane_aligner_2lane.sv
// Two-lane CSI-2 HS byte aligner: per-lane sync-byte search with bit-offset
// lock, inter-lane deskew, and a merged {lane1, lane0} word per clock that is
// forced to zero outside an aligned burst.
module csi_lane_aligner_2lane #(
  parameter logic [7:0] SYNC_BYTE = 8'hB8,
  parameter int         MAX_SKEW  = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  lane0_byte,
  input  logic [7:0]  lane1_byte,
  input  logic        lane0_hs,
  input  logic        lane1_hs,
  output logic [15:0] dout,
  output logic        dout_valid,
  output logic        locked,
  output logic [2:0]  skew,
  output logic        late_lane,
  output logic        skew_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_ONE_LOCKED,
    ST_ALIGNED,
    ST_WAIT_IDLE
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] k;
  } match_t;

  localparam logic [2:0] MAX_SKEW_C = 3'(MAX_SKEW);

  // Lowest bit offset at which the sync byte appears in a 16-bit window.
  function automatic match_t find_sync(input logic [15:0] win);
    match_t m;
    m = '0;
    for (int k = 7; k >= 0; k--) begin
      if (win[k +: 8] == SYNC_BYTE) begin
        m.hit = 1'b1;
        m.k   = 3'(k);
      end
    end
    return m;
  endfunction

  logic [7:0]  w_byte [2];
  logic [1:0]  w_hs;
  logic [15:0] w_win [2];
  match_t      w_m [2];
  logic [1:0]  w_hit;
  logic [2:0]  w_k_eff [2];
  logic [7:0]  w_a [2];
  logic [7:0]  w_tap [2];
  logic        w_fall;

  logic [7:0]  r_prev [2];
  logic [1:0]  r_hs_d;
  logic [1:0]  r_lk;
  logic [2:0]  r_k [2];
  logic [7:0]  r_dly [2][MAX_SKEW];

  state_t      r_state, w_next;
  logic [2:0]  r_cnt;
  logic        r_first;
  logic        w_lock, w_lock_late, w_first_set, w_err, w_cnt_inc, w_other_hit;
  logic [2:0]  w_lock_skew, w_skew_eff;
  logic        w_late_eff;

  logic [15:0] r_dout;
  logic        r_dout_valid;
  logic [2:0]  r_skew;
  logic        r_late;
  logic        r_skew_err;

  assign w_byte[0] = lane0_byte;
  assign w_byte[1] = lane1_byte;
  assign w_hs      = {lane1_hs, lane0_hs};
  assign w_fall    = |(r_hs_d & ~w_hs);

  // Per-lane window, sync search and aligned-byte extraction.
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    for (int l = 0; l < 2; l++) begin
      w_win[l]   = {w_byte[l], r_prev[l]};
      w_m[l]     = find_sync(w_win[l]);
      w_hit[l]   = w_hs[l] & w_m[l].hit &
                   ((r_state == ST_HUNT) | ((r_state == ST_ONE_LOCKED) & ~r_lk[l]));
      // On the match cycle the live offset is used, afterwards the frozen one.
      w_k_eff[l] = w_hit[l] ? w_m[l].k : r_k[l];
      w_a[l]     = 8'(w_win[l] >> w_k_eff[l]);
    end
  end

  // Next-state and lock/skew decisions.
  always_comb begin
    w_next      = r_state;
    w_lock      = 1'b0;
    w_lock_skew = 3'd0;
    w_lock_late = 1'b0;
    w_first_set = 1'b0;
    w_err       = 1'b0;
    w_cnt_inc   = 1'b0;
    w_other_hit = r_first ? w_hit[0] : w_hit[1];
    unique case (r_state)
      ST_IDLE: if (|w_hs) w_next = ST_HUNT;
      ST_HUNT: begin
        if (w_fall) begin
          w_next = ST_WAIT_IDLE;
        end else if (&w_hit) begin
          w_next = ST_ALIGNED;
          w_lock = 1'b1;
        end else if (|w_hit) begin
          w_next      = ST_ONE_LOCKED;
          w_first_set = 1'b1;
        end
      end
      ST_ONE_LOCKED: begin
        if (w_fall) begin
          w_next = ST_WAIT_IDLE;
        end else if (w_other_hit) begin
          w_next      = ST_ALIGNED;
          w_lock      = 1'b1;
          w_lock_skew = r_cnt;
          w_lock_late = ~r_first;
        end else if (r_cnt == MAX_SKEW_C) begin
          w_next = ST_WAIT_IDLE;
          w_err  = 1'b1;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      ST_ALIGNED:   if (w_fall) w_next = ST_WAIT_IDLE;
      ST_WAIT_IDLE: if (~|w_hs) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Tap selection: the later lane is undelayed, the earlier lane is delayed by skew.
  always_comb begin
    w_skew_eff = w_lock ? w_lock_skew : r_skew;
    w_late_eff = w_lock ? w_lock_late : r_late;
    for (int l = 0; l < 2; l++) begin
      w_tap[l] = w_a[l];
      if (1'(l) != w_late_eff) begin
        for (int d = 1; d <= MAX_SKEW; d++) begin
          if (w_skew_eff == 3'(d)) w_tap[l] = r_dly[l][d-1];
        end
      end
    end
  end

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Per-lane history, offset lock and deskew delay lines.
  // NOTE: the delay lines are reset as well so stale payload can never reach the first merged word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hs_d <= '0;
      r_lk   <= '0;
      for (int l = 0; l < 2; l++) begin
        r_prev[l] <= '0;
        r_k[l]    <= '0;
        for (int d = 0; d < MAX_SKEW; d++) r_dly[l][d] <= '0;
      end
    end else begin
      r_hs_d <= w_hs;
      for (int l = 0; l < 2; l++) begin
        r_prev[l] <= w_byte[l];
        if (r_state == ST_IDLE) begin
          r_lk[l] <= 1'b0;
        end else if (w_hit[l]) begin
          r_lk[l] <= 1'b1;
          r_k[l]  <= w_m[l].k;
        end
        r_dly[l][0] <= w_a[l];
        for (int d = 1; d < MAX_SKEW; d++) r_dly[l][d] <= r_dly[l][d-1];
      end
    end
  end

  // Skew counter, lock results and registered merged output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt        <= '0;
      r_first      <= 1'b0;
      r_skew       <= '0;
      r_late       <= 1'b0;
      r_skew_err   <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_skew_err <= w_err;
      if (w_first_set) begin
        r_cnt   <= 3'd1;
        r_first <= w_hit[1];
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_lock) begin
        r_skew <= w_lock_skew;
        r_late <= w_lock_late;
      end
      r_dout_valid <= (w_next == ST_ALIGNED);
      r_dout       <= (w_next == ST_ALIGNED) ? {w_tap[1], w_tap[0]} : 16'h0000;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign locked     = (r_state == ST_ALIGNED);
  assign skew       = r_skew;
  assign late_lane  = r_late;
  assign skew_err   = r_skew_err;

endmodule

// File: doc/csi_lane_aligner_2lane.md
Name: csi_lane_aligner_2lane

Overview:
- Sits between the two-lane D-PHY HS byte deserialisers and the CSI-2 packet capture stage.
- Per lane: finds the HS sync byte (0xB8) at any bit offset and locks the byte boundary.
- Deskews the two lanes by up to MAX_SKEW cycles and emits one merged 16-bit word per clock, {lane1, lane0}.
- Output is forced to 16'h0000 outside an aligned burst, so the capture stage always sees at least one zero word followed by 16'hB8B8 at packet start.

Parameters:
- SYNC_BYTE, 8'hB8, HS sync pattern searched on each lane.
- MAX_SKEW, 4, maximum inter-lane lock skew in cycles (legal 1..7).

Ports:
- clk  input  1  byte clock.
- rstn  input  1  asynchronous active-low reset.
- lane0_byte  input  8  raw deserialised byte, lane 0, LSB first in time.
- lane1_byte  input  8  raw deserialised byte, lane 1.
- lane0_hs  input  1  lane 0 HS-active flag from the PHY.
- lane1_hs  input  1  lane 1 HS-active flag.
- dout  output  16  merged word {lane1_aligned, lane0_aligned}; 0 when not aligned.
- dout_valid  output  1  high while dout carries aligned data.
- locked  output  1  FSM in ALIGNED.
- skew  output  3  applied delay (cycles) on the earlier lane; held until the next lock.
- late_lane  output  1  0 = lane0 locked last, 1 = lane1 locked last; held.
- skew_err  output  1  one-cycle pulse on skew timeout.

Behaviour:
- Reset: dout=0, dout_valid=0, locked=0, skew=0, late_lane=0, skew_err=0; FSM=IDLE; delay lines and offsets cleared.
- Reset mid-burst: all outputs go to their reset values immediately (async).
- Per-lane window: W = {current input byte, previous input byte (registered)}.
  - Candidate k = W[k+7:k], k = 0..7.
  - Lane match = lane_hs high and any candidate == SYNC_BYTE; the lowest k wins.
  - On lock the lane's k is frozen. Search is disabled until the FSM returns to IDLE, so 0xB8 in payload is never re-matched.
- Aligned byte is registered each cycle: A = W[k+7:k] with the frozen k.
- Each lane feeds a MAX_SKEW-deep shift register of A; tap d selects A delayed by d cycles.
- FSM states:
  - IDLE:
    - if lane0_hs or lane1_hs -> HUNT.
  - HUNT:
    - if either hs falls -> WAIT_IDLE.
    - both lanes match in the same cycle -> ALIGNED, skew=0.
    - one lane matches -> ONE_LOCKED, skew_cnt=1, record the lane.
  - ONE_LOCKED:
    - if the other lane matches -> ALIGNED. Earlier lane delay = skew_cnt; skew=skew_cnt; late_lane = the other lane.
    - else if skew_cnt==MAX_SKEW -> skew_err pulse, WAIT_IDLE.
    - else skew_cnt+1.
    - if either hs falls -> WAIT_IDLE, no error.
  - ALIGNED:
    - dout_valid=1.
    - dout = {lane1 tap, lane0 tap}; the later lane uses tap 0, the earlier lane uses tap skew.
    - if either hs falls -> WAIT_IDLE.
  - WAIT_IDLE:
    - dout=0, dout_valid=0.
    - if both hs low -> IDLE.
    - Simultaneous rise of one hs while the other is still high stays in WAIT_IDLE.
- Latency: the later lane's sync byte fully present on its input in cycle N gives dout==16'hB8B8 in cycle N+2.
  - For k>0 the match cycle is the one in which the second byte of the sync arrives.
- dout is registered; dout==0 in every cycle where dout_valid==0, so the zero-before-B8B8 condition always holds.
- The first dout_valid cycle carries the sync word. Burst end: dout returns to 0 one cycle after the hs fall is sampled.

Test Plan:
1. Both lanes offset 0, zero skew, sync in cycle N then header 0x2A... -> dout=0 through N+1, dout=16'hB8B8 at N+2, next word = {byte1,byte0} of the header; skew=0.
2. lane0 shifted 3 bits, lane1 shifted 5 bits, no skew -> lock at k=3/k=5, dout=16'hB8B8, payload bytes reconstructed bit-exact over a 720-byte line.
3. lane1 sync 2 cycles after lane0 -> skew=2, late_lane=1, dout=16'hB8B8 two cycles after lane1's match cycle, payload pairs correctly time-matched.
4. lane1 never sends sync, MAX_SKEW=4 -> skew_err single pulse 4 cycles after lane0's lock; dout stays 0 until both hs low; the next burst aligns normally.
5. Payload containing byte 0xB8 after lock, lane0_hs drops mid-line -> no relock; dout=0 and dout_valid=0 the cycle after the drop; no error pulse.
6. rstn asserted during ALIGNED -> all outputs 0 immediately; after release, a fresh burst locks as in scenario 1.
